// File: rtl/cnt4_ctrl_pkg.sv
// Shared definitions for the 4-bit timer controller slice.
// Holds the controller state encoding, the default datapath width and a
// saturating-increment helper used by the wrap counter.
package cnt4_ctrl_pkg;

  localparam int unsigned CNT4_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HOLD = 2'b10,
    ST_DONE = 2'b11
  } cnt4_state_e;

  // Increment value by one, sticking at max_value instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] max_value);
    return (value >= max_value) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/cnt4_core.sv
// WIDTH-bit synchronous up-counter datapath.
// clr has priority over en; rc flags the all-ones value.
module cnt4_core
  import cnt4_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = CNT4_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             rc
);

  // Count register: clear wins, otherwise advance when enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign rc = &count;

endmodule

// File: rtl/cnt4_timer_ctrl.sv
// Sequencing controller around the cnt4_core counter datapath.
// Handles start/stop/hold, one-shot vs periodic runs, terminal-count tick,
// done flag and a saturating count of completed periods.
// Optional feature macro: CNT4_PRESCALE_EN (adds a PRESCALE_DIV clock prescaler
// in front of the count advance).
module cnt4_timer_ctrl
  import cnt4_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH        = CNT4_WIDTH,
  parameter int unsigned PRESCALE_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             start_ready,
  input  logic             stop,
  input  logic             hold,
  input  logic             periodic,
  input  logic [WIDTH-1:0] period,
  output logic             busy,
  output logic             done,
  output logic             tick,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] wrap_cnt
);

  localparam logic [31:0] WRAP_MAX = 32'((64'd1 << WIDTH) - 64'd1);

  if (PRESCALE_DIV < 2) begin : g_bad_prescale
    $error("PRESCALE_DIV must be at least 2");
  end

  cnt4_state_e      state_q, state_d;
  logic [WIDTH-1:0] period_q;
  logic             mode_q;
  logic [WIDTH-1:0] wrap_q;

  logic             start_acc;
  logic             stop_busy;
  logic             run_en;
  logic             pre_strobe;
  logic             adv;
  logic             at_term;
  logic             core_clr;
  logic             core_en;
  logic             core_rc;

  assign busy        = (state_q == ST_RUN) || (state_q == ST_HOLD);
  assign done        = (state_q == ST_DONE);
  assign start_ready = (state_q == ST_IDLE) || (state_q == ST_DONE);

  assign start_acc = start && start_ready;
  assign stop_busy = stop && busy;

  // HOLD with hold released counts as running: the count resumes on that very
  // cycle, so a hold of N cycles delays the tick by exactly N cycles.
  assign run_en = busy && !hold && !stop;

`ifdef CNT4_PRESCALE_EN
  localparam int unsigned      PRE_W    = (PRESCALE_DIV > 2) ? $clog2(PRESCALE_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE_DIV - 1);

  logic [PRE_W-1:0] pre_q;

  // Prescaler: cycles 0..PRESCALE_DIV-1 while running, frozen while held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
    end else if (start_acc || stop_busy) begin
      pre_q <= '0;
    end else if (run_en) begin
      pre_q <= (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
    end
  end

  assign pre_strobe = (pre_q == PRE_LAST);
`else
  assign pre_strobe = 1'b1;
`endif

  assign adv = run_en && pre_strobe;

  // An all-ones terminal count is taken from the core's rc flag directly.
  assign at_term = (period_q == '1) ? core_rc : (count == period_q);

  assign tick     = adv && at_term;
  assign core_clr = start_acc || tick || stop_busy;
  assign core_en  = adv && !at_term;

  cnt4_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (core_clr),
    .en    (core_en),
    .count (count),
    .rc    (core_rc)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: stop beats hold, hold beats terminal-count completion.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_acc) state_d = ST_RUN;
      end
      ST_RUN, ST_HOLD: begin
        if (stop)                 state_d = ST_IDLE;
        else if (hold)            state_d = ST_HOLD;
        else if (tick && !mode_q) state_d = ST_DONE;
        else                      state_d = ST_RUN;
      end
      ST_DONE: begin
        if (start_acc) state_d = ST_RUN;
        else if (stop) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Run configuration is captured only when a start is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_q <= '0;
      mode_q   <= 1'b0;
    end else if (start_acc) begin
      period_q <= period;
      mode_q   <= periodic;
    end
  end

  // Completed-period counter: cleared on start, saturating on each tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_q <= '0;
    end else if (start_acc) begin
      wrap_q <= '0;
    end else if (tick) begin
      wrap_q <= WIDTH'(sat_inc(32'(wrap_q), WRAP_MAX));
    end
  end

  assign wrap_cnt = wrap_q;

endmodule

// File: tb/tb_cnt4_timer_ctrl.sv
// Scoreboard bench for cnt4_timer_ctrl.
// Stimulus pushes expected tick cycles and per-cycle status values into
// queues; an independent monitor pops and compares on the falling edge.
module tb_cnt4_timer_ctrl;
  import cnt4_ctrl_pkg::*;

  localparam int unsigned W = 4;

  logic         clk      = 1'b0;
  logic         rst_n    = 1'b0;
  logic         start    = 1'b0;
  logic         stop     = 1'b0;
  logic         hold     = 1'b0;
  logic         periodic = 1'b0;
  logic [W-1:0] period   = '0;
  logic         start_ready, busy, done, tick;
  logic [W-1:0] count, wrap_cnt;

  always #5 clk = ~clk;

  cnt4_timer_ctrl #(
    .WIDTH        (W),
    .PRESCALE_DIV (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .start_ready (start_ready),
    .stop        (stop),
    .hold        (hold),
    .periodic    (periodic),
    .period      (period),
    .busy        (busy),
    .done        (done),
    .tick        (tick),
    .count       (count),
    .wrap_cnt    (wrap_cnt)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int unsigned {S_COUNT, S_BUSY, S_DONE, S_WRAP, S_READY} sig_e;
  typedef struct {
    int unsigned cyc;
    sig_e        sig;
    int unsigned val;
    string       name;
  } exp_t;

  exp_t        chk_q[$];
  int unsigned tick_q[$];
  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  function automatic void expect_at(int unsigned c, sig_e s, int unsigned v, string nm);
    exp_t        e;
    int unsigned i;
    e = '{c, s, v, nm};
    i = 0;
    while (i < chk_q.size() && chk_q[i].cyc <= c) i++;
    chk_q.insert(i, e);
  endfunction

  function automatic int unsigned actual(sig_e s);
    case (s)
      S_COUNT: return 32'(count);
      S_BUSY:  return 32'(busy);
      S_DONE:  return 32'(done);
      S_WRAP:  return 32'(wrap_cnt);
      default: return 32'(start_ready);
    endcase
  endfunction

  // Monitor: tick events against the tick queue, status against the check queue.
  always @(negedge clk) begin
    if (tick_q.size() > 0 && tick_q[0] == cyc) begin
      void'(tick_q.pop_front());
      n_chk++;
      if (tick !== 1'b1) begin
        n_fail++;
        $display("FAIL tick_missing: cycle %0d tick=%b required 1", cyc, tick);
      end
    end else if (tick !== 1'b0) begin
      n_chk++;
      n_fail++;
      $display("FAIL tick_unexpected: cycle %0d tick=%b required 0", cyc, tick);
    end
    while (chk_q.size() > 0 && chk_q[0].cyc <= cyc) begin
      exp_t        e;
      int unsigned a;
      e = chk_q.pop_front();
      a = actual(e.sig);
      n_chk++;
      if (a !== e.val || e.cyc != cyc) begin
        n_fail++;
        $display("FAIL %s: cycle %0d got %0d required %0d", e.name, cyc, a, e.val);
      end
    end
  end

  task automatic tic();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int unsigned c);
    while (cyc < c) tic();
  endtask

  // Drive start for one cycle; s is the cycle during which start was high.
  task automatic issue_start(input logic [W-1:0] p, input logic per, output int unsigned s);
    start    = 1'b1;
    period   = p;
    periodic = per;
    s        = cyc;
    tic();
    start    = 1'b0;
  endtask

  initial begin
    int unsigned s;

    repeat (3) tic();
    rst_n = 1'b1;
    expect_at(cyc, S_COUNT, 0, "rst_count");
    expect_at(cyc, S_BUSY,  0, "rst_busy");
    expect_at(cyc, S_DONE,  0, "rst_done");
    expect_at(cyc, S_WRAP,  0, "rst_wrap");
    expect_at(cyc, S_READY, 1, "rst_ready");
    tic();

`ifdef CNT4_PRESCALE_EN
    // Prescaled periodic run, period=1, divide by 4: tick every 8 cycles.
    issue_start(4'd1, 1'b1, s);
    for (int k = 1; k <= 3; k++) begin
      tick_q.push_back(s + 8 * k);
      expect_at(s + 8 * k + 1, S_WRAP, k, "pre_wrap");
    end
    expect_at(s + 4, S_COUNT, 0, "pre_count_hold0");
    expect_at(s + 5, S_COUNT, 1, "pre_count_adv");
    wait_until(s + 26);
    stop = 1'b1;
    tic();
    stop = 1'b0;
    expect_at(s + 27, S_BUSY, 0, "pre_stop_busy");
    expect_at(s + 27, S_WRAP, 3, "pre_stop_wrap");
    wait_until(s + 29);
`else
    // One-shot, period=5.
    issue_start(4'd5, 1'b0, s);
    for (int k = 0; k <= 5; k++) expect_at(s + 1 + k, S_COUNT, k, "os_count");
    tick_q.push_back(s + 6);
    expect_at(s + 3, S_BUSY,  1, "os_busy");
    expect_at(s + 3, S_READY, 0, "os_ready");
    expect_at(s + 7, S_DONE,  1, "os_done");
    expect_at(s + 7, S_BUSY,  0, "os_done_busy");
    expect_at(s + 7, S_WRAP,  1, "os_wrap");
    expect_at(s + 7, S_COUNT, 0, "os_done_count");
    wait_until(s + 9);

    // Periodic, period=2: tick every 3 cycles, wrap_cnt saturates at 15.
    issue_start(4'd2, 1'b1, s);
    for (int k = 1; k <= 17; k++) begin
      tick_q.push_back(s + 3 * k);
      expect_at(s + 3 * k + 1, S_WRAP, (k > 15) ? 15 : k, "per_wrap");
    end
    expect_at(s + 6, S_COUNT, 2, "per_ignore_start");
    wait_until(s + 4);
    start    = 1'b1;
    period   = 4'd7;
    periodic = 1'b0;
    tic();
    start    = 1'b0;
    wait_until(s + 52);
    stop = 1'b1;
    tic();
    stop = 1'b0;
    expect_at(s + 53, S_BUSY,  0, "per_stop_busy");
    expect_at(s + 53, S_COUNT, 0, "per_stop_count");
    expect_at(s + 53, S_WRAP,  15, "per_stop_wrap");
    wait_until(s + 55);

    // Hold 4 cycles at count=3 (period=5 one-shot): tick moves from s+6 to s+10.
    issue_start(4'd5, 1'b0, s);
    for (int k = 4; k <= 8; k++) expect_at(s + k, S_COUNT, 3, "hold_count");
    expect_at(s + 9, S_COUNT, 4, "hold_resume");
    expect_at(s + 6, S_BUSY,  1, "hold_busy");
    tick_q.push_back(s + 10);
    expect_at(s + 11, S_DONE, 1, "hold_done");
    wait_until(s + 4);
    hold = 1'b1;
    repeat (4) tic();
    hold = 1'b0;
    wait_until(s + 12);
    expect_at(s + 12, S_DONE, 1, "done_level");
    stop = 1'b1;
    tic();
    stop = 1'b0;
    expect_at(s + 13, S_DONE,  0, "done_stop");
    expect_at(s + 13, S_READY, 1, "done_stop_ready");
    wait_until(s + 15);

    // Stop in the terminal-count cycle suppresses the tick.
    issue_start(4'd3, 1'b1, s);
    expect_at(s + 4, S_COUNT, 3, "stop_term_count");
    wait_until(s + 4);
    stop = 1'b1;
    tic();
    stop = 1'b0;
    expect_at(s + 5, S_BUSY,  0, "stop_term_busy");
    expect_at(s + 5, S_COUNT, 0, "stop_term_count0");
    expect_at(s + 5, S_WRAP,  0, "stop_term_wrap");
    wait_until(s + 7);

    // Period 0 periodic: tick every cycle.
    issue_start(4'd0, 1'b1, s);
    for (int k = 1; k <= 5; k++) tick_q.push_back(s + k);
    expect_at(s + 3, S_COUNT, 0, "p0_count");
    expect_at(s + 6, S_WRAP,  5, "p0_wrap");
    wait_until(s + 6);
    stop = 1'b1;
    tic();
    stop = 1'b0;
    expect_at(s + 7, S_BUSY, 0, "p0_stop_busy");
    expect_at(s + 7, S_WRAP, 5, "p0_stop_wrap");
    wait_until(s + 9);
`endif

    // Asynchronous reset in the middle of a run.
    issue_start(4'd9, 1'b0, s);
    expect_at(s + 3, S_COUNT, 2, "mid_count");
    expect_at(s + 3, S_BUSY,  1, "mid_busy");
    wait_until(s + 4);
    rst_n = 1'b0;
    expect_at(s + 4, S_COUNT, 0, "arst_count");
    expect_at(s + 4, S_BUSY,  0, "arst_busy");
    expect_at(s + 4, S_DONE,  0, "arst_done");
    expect_at(s + 4, S_READY, 1, "arst_ready");
    repeat (2) tic();
    rst_n = 1'b1;
    repeat (3) tic();

    while (chk_q.size() > 0) begin
      exp_t e;
      e = chk_q.pop_front();
      n_chk++;
      n_fail++;
      $display("FAIL %s: cycle %0d check never reached, required %0d", e.name, e.cyc, e.val);
    end
    while (tick_q.size() > 0) begin
      int unsigned t;
      t = tick_q.pop_front();
      n_chk++;
      n_fail++;
      $display("FAIL tick_missing: cycle %0d tick never seen, required 1", t);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
